// File: rtl/instr_fetch_if.sv
// Fetch-unit bus bundle: instruction-memory request/response, decode handoff and redirect.
// The master modport is the fetch unit; the slave modport is memory plus decode/branch logic.
interface instr_fetch_if #(
  parameter int DATA_BUS_WIDTH = 32
);
  logic                      imem_req_valid;
  logic                      imem_req_ready;
  logic [DATA_BUS_WIDTH-1:0] imem_addr;
  logic                      imem_rsp_valid;
  logic [DATA_BUS_WIDTH-1:0] imem_rsp_data;
  logic [DATA_BUS_WIDTH-1:0] instr;
  logic [DATA_BUS_WIDTH-1:0] instr_pc;
  logic                      instr_valid;
  logic                      instr_ready;
  logic                      redirect;
  logic [DATA_BUS_WIDTH-1:0] redirect_pc;
  logic                      fetch_misaligned;

  modport master (
    output imem_req_valid, imem_addr, instr, instr_pc, instr_valid, fetch_misaligned,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready, redirect, redirect_pc
  );

  modport slave (
    input  imem_req_valid, imem_addr, instr, instr_pc, instr_valid, fetch_misaligned,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/instr_fetch.sv
// Single-outstanding instruction fetch unit: requests sequential words, holds one instruction
// for decode, and squashes in-flight or held work when a redirect arrives.
module instr_fetch #(
  parameter int                        DATA_BUS_WIDTH = 32,
  parameter logic [DATA_BUS_WIDTH-1:0] RESET_PC       = 32'h0000_0000
) (
  input logic           clk,
  input logic           rst_n,
  instr_fetch_if.master bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    FULL = 2'd3
  } state_t;

  localparam logic [DATA_BUS_WIDTH-1:0] ZERO    = {DATA_BUS_WIDTH{1'b0}};
  localparam logic [DATA_BUS_WIDTH-1:0] PC_STEP = DATA_BUS_WIDTH'(32'd4);

  state_t                    state_r;
  logic [DATA_BUS_WIDTH-1:0] pc_r;
  logic [DATA_BUS_WIDTH-1:0] inflight_pc_r;
  logic [DATA_BUS_WIDTH-1:0] addr_r;
  logic [DATA_BUS_WIDTH-1:0] instr_r;
  logic [DATA_BUS_WIDTH-1:0] instr_pc_r;
  logic                      drop_r;
  logic                      req_valid_r;
  logic                      instr_valid_r;
  logic                      misaligned_r;
  logic [DATA_BUS_WIDTH-1:0] target_s;
  logic [DATA_BUS_WIDTH-1:0] pc_next_s;

  assign target_s  = {bus.redirect_pc[DATA_BUS_WIDTH-1:2], 2'b00};
  assign pc_next_s = pc_r + PC_STEP;

  // Fetch FSM; every output is a register written alongside the state transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      pc_r          <= RESET_PC;
      inflight_pc_r <= ZERO;
      addr_r        <= ZERO;
      instr_r       <= ZERO;
      instr_pc_r    <= ZERO;
      drop_r        <= 1'b0;
      req_valid_r   <= 1'b0;
      instr_valid_r <= 1'b0;
      misaligned_r  <= 1'b0;
    end else begin
      misaligned_r <= bus.redirect & (|bus.redirect_pc[1:0]);
      case (state_r)
        IDLE: begin
          req_valid_r <= 1'b1;
          state_r     <= REQ;
          if (bus.redirect) begin
            pc_r   <= target_s;
            addr_r <= target_s;
          end else begin
            addr_r <= pc_r;
          end
        end
        REQ: begin
          if (bus.redirect) begin
            pc_r <= target_s;
            // An accepted request is already in memory; its answer must be thrown away.
            if (bus.imem_req_ready) begin
              req_valid_r <= 1'b0;
              drop_r      <= 1'b1;
              state_r     <= WAIT;
            end else begin
              addr_r <= target_s;
            end
          end else if (bus.imem_req_ready) begin
            inflight_pc_r <= pc_r;
            pc_r          <= pc_next_s;
            req_valid_r   <= 1'b0;
            state_r       <= WAIT;
          end else begin
            state_r <= REQ;
          end
        end
        WAIT: begin
          if (bus.redirect) begin
            pc_r <= target_s;
            if (bus.imem_rsp_valid) begin
              drop_r      <= 1'b0;
              req_valid_r <= 1'b1;
              addr_r      <= target_s;
              state_r     <= REQ;
            end else begin
              drop_r <= 1'b1;
            end
          end else if (bus.imem_rsp_valid) begin
            if (drop_r) begin
              drop_r      <= 1'b0;
              req_valid_r <= 1'b1;
              addr_r      <= pc_r;
              state_r     <= REQ;
            end else begin
              instr_r       <= bus.imem_rsp_data;
              instr_pc_r    <= inflight_pc_r;
              instr_valid_r <= 1'b1;
              state_r       <= FULL;
            end
          end else begin
            state_r <= WAIT;
          end
        end
        FULL: begin
          // A redirect squashes the held word even when decode takes it this cycle.
          if (bus.redirect) begin
            pc_r          <= target_s;
            instr_valid_r <= 1'b0;
            req_valid_r   <= 1'b1;
            addr_r        <= target_s;
            state_r       <= REQ;
          end else if (bus.instr_ready) begin
            instr_valid_r <= 1'b0;
            req_valid_r   <= 1'b1;
            addr_r        <= pc_r;
            state_r       <= REQ;
          end else begin
            state_r <= FULL;
          end
        end
        default: begin
          state_r       <= IDLE;
          drop_r        <= 1'b0;
          req_valid_r   <= 1'b0;
          instr_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.imem_req_valid   = req_valid_r;
  assign bus.imem_addr        = addr_r;
  assign bus.instr            = instr_r;
  assign bus.instr_pc         = instr_pc_r;
  assign bus.instr_valid      = instr_valid_r;
  assign bus.fetch_misaligned = misaligned_r;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios followed by a randomized phase checked against a
// program-order model (sequential pc stream restarted at each aligned redirect target).
module tb_instr_fetch;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  instr_fetch_if #(.DATA_BUS_WIDTH(32)) bus ();

  instr_fetch #(.DATA_BUS_WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory contents used in the random phase: distinct word per address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[17:2], a[17:2]} ^ 32'h6A09_E667;
  endfunction

  logic [31:0] req_a [3];
  logic [31:0] first_instr, first_pc, exp_pc, exp_req, rpc, mem_addr;
  logic        got_instr, mem_pend, hs, held, acc, deliver, exp_mis, redir;
  int          nreq, mem_lat, hs_count;

  initial begin
    rst_n = 1'b1;
    bus.imem_req_ready = 1'b0; bus.imem_rsp_valid = 1'b0; bus.imem_rsp_data = 32'h0;
    bus.instr_ready = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = 32'h0;
    #2 rst_n = 1'b0;
    tick(); tick();

    // Reset state
    chk("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
    chk("rst_addr", bus.imem_addr, 32'h0);
    chk("rst_instr", bus.instr, 32'h0);
    chk("rst_instr_pc", bus.instr_pc, 32'h0);
    chk("rst_instr_valid", 32'(bus.instr_valid), 32'd0);
    chk("rst_misaligned", 32'(bus.fetch_misaligned), 32'd0);

    // Streaming fetch with memory always ready/responding
    for (int i = 0; i < 3; i++) req_a[i] = 32'hFFFF_FFFF;
    bus.imem_req_ready = 1'b1; bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'h00A0_0093;
    bus.instr_ready = 1'b1;
    rst_n = 1'b1;
    nreq = 0; got_instr = 1'b0; first_instr = 32'h0; first_pc = 32'hFFFF_FFFF;
    for (int c = 0; c < 40 && nreq < 3; c++) begin
      if (bus.instr_valid && bus.instr_ready && !got_instr) begin
        first_instr = bus.instr; first_pc = bus.instr_pc; got_instr = 1'b1;
      end
      if (bus.imem_req_valid && bus.imem_req_ready) begin
        req_a[nreq] = bus.imem_addr; nreq++;
      end
      tick();
    end
    bus.instr_ready = 1'b0;
    chk("stream_req_count", 32'(nreq), 32'd3);
    chk("stream_req0", req_a[0], 32'h0);
    chk("stream_req1", req_a[1], 32'h4);
    chk("stream_req2", req_a[2], 32'h8);
    chk("stream_first_instr", first_instr, 32'h00A0_0093);
    chk("stream_first_pc", first_pc, 32'h0);

    // Decode stall: held instruction stays put, no new request
    for (int c = 0; c < 10 && !bus.instr_valid; c++) tick();
    chk("stall_reach_full", 32'(bus.instr_valid), 32'd1);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("stall_instr", bus.instr, 32'h00A0_0093);
      chk("stall_instr_pc", bus.instr_pc, 32'h8);
      chk("stall_valid", 32'(bus.instr_valid), 32'd1);
      chk("stall_no_req", 32'(bus.imem_req_valid), 32'd0);
    end

    // Redirect while waiting; stale response arrives two cycles later
    bus.imem_rsp_valid = 1'b0; bus.instr_ready = 1'b1;
    tick();
    chk("redir_req_addr_c", bus.imem_addr, 32'hC);
    tick();
    bus.instr_ready = 1'b0; bus.redirect = 1'b1; bus.redirect_pc = 32'h100;
    tick();
    bus.redirect = 1'b0;
    chk("redir_wait_valid", 32'(bus.instr_valid), 32'd0);
    tick();
    bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'hDEAD_BEEF;
    tick();
    bus.imem_rsp_valid = 1'b0;
    chk("redir_drop_valid", 32'(bus.instr_valid), 32'd0);
    chk("redir_req_valid", 32'(bus.imem_req_valid), 32'd1);
    chk("redir_req_addr", bus.imem_addr, 32'h100);
    tick();
    bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'h1234_5678;
    tick();
    bus.imem_rsp_valid = 1'b0;
    chk("redir_instr_valid", 32'(bus.instr_valid), 32'd1);
    chk("redir_instr_pc", bus.instr_pc, 32'h100);
    chk("redir_instr", bus.instr, 32'h1234_5678);

    // Misaligned redirect from FULL
    bus.redirect = 1'b1; bus.redirect_pc = 32'h103;
    tick();
    bus.redirect = 1'b0; bus.imem_req_ready = 1'b0;
    chk("mis_pulse", 32'(bus.fetch_misaligned), 32'd1);
    chk("mis_addr", bus.imem_addr, 32'h100);
    chk("mis_squash", 32'(bus.instr_valid), 32'd0);
    tick();
    chk("mis_one_cycle", 32'(bus.fetch_misaligned), 32'd0);
    chk("mis_addr_stable", bus.imem_addr, 32'h100);

    // pc wrap at the top of the address space
    bus.redirect = 1'b1; bus.redirect_pc = 32'hFFFF_FFFC;
    tick();
    bus.redirect = 1'b0; bus.imem_req_ready = 1'b1;
    chk("wrap_addr_top", bus.imem_addr, 32'hFFFF_FFFC);
    tick();
    bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'hCAFE_0001;
    tick();
    bus.imem_rsp_valid = 1'b0;
    chk("wrap_instr_pc", bus.instr_pc, 32'hFFFF_FFFC);
    bus.instr_ready = 1'b1;
    tick();
    chk("wrap_next_valid", 32'(bus.imem_req_valid), 32'd1);
    chk("wrap_next_addr", bus.imem_addr, 32'h0);

    // Reset mid-WAIT, late response after release
    bus.instr_ready = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_req_valid", 32'(bus.imem_req_valid), 32'd0);
    chk("midrst_addr", bus.imem_addr, 32'h0);
    chk("midrst_instr_pc", bus.instr_pc, 32'h0);
    chk("midrst_valid", 32'(bus.instr_valid), 32'd0);
    tick();
    bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'hBAD0_BAD0; bus.imem_req_ready = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("late_rsp_valid0", 32'(bus.instr_valid), 32'd0);
    chk("late_req_valid", 32'(bus.imem_req_valid), 32'd1);
    chk("late_req_addr", bus.imem_addr, 32'h0);
    tick();
    bus.imem_rsp_valid = 1'b0;
    chk("late_rsp_valid1", 32'(bus.instr_valid), 32'd0);

    // Randomized traffic against the program-order model
    exp_pc = 32'h0; exp_req = 32'h0; mem_pend = 1'b0; mem_addr = 32'h0; mem_lat = 0;
    hs_count = 0;
    for (int c = 0; c < 3000; c++) begin
      bus.imem_req_ready = ($urandom_range(0, 3) != 0);
      bus.instr_ready    = ($urandom_range(0, 2) != 0);
      redir              = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      else rpc = 32'($urandom_range(0, 1023));
      bus.redirect    = redir;
      bus.redirect_pc = rpc;
      deliver = mem_pend && (mem_lat == 0);
      bus.imem_rsp_valid = deliver;
      bus.imem_rsp_data  = deliver ? mem_word(mem_addr) : $urandom;

      if (bus.imem_req_valid) chk("rnd_req_addr", bus.imem_addr, exp_req);
      hs   = bus.instr_valid && bus.instr_ready;
      held = bus.instr_valid && !bus.instr_ready && !redir;
      acc  = bus.imem_req_valid && bus.imem_req_ready;
      if (hs) begin
        chk("rnd_instr_pc", bus.instr_pc, exp_pc);
        chk("rnd_instr", bus.instr, mem_word(exp_pc));
        exp_pc = exp_pc + 32'd4;
        hs_count++;
      end
      if (acc) begin
        chk("rnd_one_outstanding", 32'(mem_pend), 32'd0);
        mem_addr = bus.imem_addr;
        exp_req  = exp_req + 32'd4;
      end
      exp_mis = redir && (rpc[1:0] != 2'b00);
      if (redir) begin
        exp_pc  = {rpc[31:2], 2'b00};
        exp_req = {rpc[31:2], 2'b00};
      end

      tick();

      if (deliver) mem_pend = 1'b0;
      else if (mem_pend && mem_lat > 0) mem_lat--;
      if (acc) begin
        mem_pend = 1'b1;
        mem_lat  = $urandom_range(0, 3);
      end
      chk("rnd_misaligned", 32'(bus.fetch_misaligned), 32'(exp_mis));
      if (held) chk("rnd_hold_valid", 32'(bus.instr_valid), 32'd1);
      if (redir) chk("rnd_redir_squash", 32'(bus.instr_valid), 32'd0);
    end
    chk("rnd_liveness", 32'(hs_count > 100), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
